// File: rtl/uart_pix_len_frame_tx.sv
// Pixel-length frame transmitter: serialises x/y lengths into a headered byte frame for the UART TX.
// Optional UART_FRAME_CKSUM_EN appends a modulo-256 sum of the four payload bytes.
module uart_pix_len_frame_tx #(
    parameter logic [7:0] HDR0        = 8'h55,
    parameter logic [7:0] HDR1        = 8'hAA,
    parameter int         TIMEOUT_CYC = 16384
) (
    input  logic        sys_clk_96M,
    input  logic        sys_rst_n,
    input  logic [10:0] x_pix_len,
    input  logic [10:0] y_pix_len,
    input  logic        pix_len_update,
    output logic        txd_en,
    output logic [7:0]  txd_data,
    input  logic        txd_flag,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [7:0]  drop_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
`ifdef UART_FRAME_CKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [10:0]        r_x;
    logic [10:0]        r_y;
    logic [10:0]        r_x_sh;
    logic [10:0]        r_y_sh;
    logic               r_pending;
    logic [2:0]         r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_txd_en;
    logic [7:0]         r_txd_data;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_timeout_err;
    logic [7:0]         r_drop_cnt;
    logic               w_start;
    logic               w_timeout;
    logic               w_last_ack;
    logic [7:0]         w_byte;

    assign w_start    = (r_state == IDLE) && (pix_len_update || r_pending);
    assign w_timeout  = (r_state == WAIT) && !txd_flag && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_last_ack = (r_state == WAIT) && txd_flag && (r_idx == LAST_IDX);

`ifdef UART_FRAME_CKSUM_EN
    logic [7:0] w_cksum;
    assign w_cksum = {5'b0, r_x[10:8]} + r_x[7:0] + {5'b0, r_y[10:8]} + r_y[7:0];
`endif

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = HDR0;
            3'd1:    w_byte = HDR1;
            3'd2:    w_byte = {5'b0, r_x[10:8]};
            3'd3:    w_byte = r_x[7:0];
            3'd4:    w_byte = {5'b0, r_y[10:8]};
            3'd5:    w_byte = r_y[7:0];
`ifdef UART_FRAME_CKSUM_EN
            default: w_byte = w_cksum;
`else
            default: w_byte = 8'h00;
`endif
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = SEND;
            SEND: w_state_nxt = WAIT;
            WAIT: begin
                // An acknowledge in the final counted cycle still wins over the abort.
                if (txd_flag)       w_state_nxt = (r_idx == LAST_IDX) ? DONE : SEND;
                else if (w_timeout) w_state_nxt = IDLE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_x_sh     <= '0;
            r_y_sh     <= '0;
            r_pending  <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_drop_cnt <= '0;
        end else begin
            // A fresh pulse always beats the shadow copy, so the latest values win.
            if (w_start) begin
                r_x   <= pix_len_update ? x_pix_len : r_x_sh;
                r_y   <= pix_len_update ? y_pix_len : r_y_sh;
                r_idx <= '0;
            end else if ((r_state == WAIT) && txd_flag && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + 3'd1;
            end
            if (pix_len_update && (r_state != IDLE)) begin
                r_x_sh    <= x_pix_len;
                r_y_sh    <= y_pix_len;
                r_pending <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
            if (pix_len_update && r_pending && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
            if (r_state == SEND)      r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_txd_en      <= 1'b0;
            r_txd_data    <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_txd_en      <= (r_state == SEND);
            if (r_state == SEND) r_txd_data <= w_byte;
            r_busy        <= (w_state_nxt != IDLE);
            r_frame_done  <= w_last_ack;
            r_timeout_err <= w_timeout;
        end
    end

    assign txd_en      = r_txd_en;
    assign txd_data    = r_txd_data;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout_err;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_uart_pix_len_frame_tx.sv
// Bench for uart_pix_len_frame_tx: auto-acknowledging transmitter model plus a byte-level frame reference.
module tb_uart_pix_len_frame_tx;

    localparam int T = 16384;
`ifdef UART_FRAME_CKSUM_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x_in;
    logic [10:0] y_in;
    logic        upd;
    logic        auto_flag;
    logic        man_flag;
    logic        txd_flag;
    logic        txd_en;
    logic [7:0]  txd_data;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;
    logic [7:0]  drop_cnt;

    assign txd_flag = auto_flag | man_flag;

    uart_pix_len_frame_tx dut (
        .sys_clk_96M    (clk),
        .sys_rst_n      (rst_n),
        .x_pix_len      (x_in),
        .y_pix_len      (y_in),
        .pix_len_update (upd),
        .txd_en         (txd_en),
        .txd_data       (txd_data),
        .txd_flag       (txd_flag),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err),
        .drop_cnt       (drop_cnt)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int en_idx = 0;
    int withhold_at = -1;
    int flag_dly = 100;
    int countdown = 0;
    int exp_drop = 0;
    logic [7:0] sent_q[$];
    int en_cyc_q[$];
    int fd_cyc_q[$];
    int to_cyc_q[$];

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (txd_en === 1'b1) begin
            sent_q.push_back(txd_data);
            en_cyc_q.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_cyc_q.push_back(cyc);
        if (timeout_err === 1'b1) to_cyc_q.push_back(cyc);
    end

    // Transmitter model: acknowledges each byte flag_dly cycles after its txd_en.
    initial begin
        auto_flag = 1'b0;
        forever begin
            @(negedge clk);
            auto_flag = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) auto_flag = 1'b1;
            end
            if (txd_en === 1'b1) begin
                if (en_idx != withhold_at) countdown = flag_dly;
                en_idx++;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int x, input int y, input int i);
        int sum;
        sum = ((x / 256) + (x % 256) + (y / 256) + (y % 256)) % 256;
        case (i)
            0:       return 8'h55;
            1:       return 8'hAA;
            2:       return 8'(x / 256);
            3:       return 8'(x % 256);
            4:       return 8'(y / 256);
            5:       return 8'(y % 256);
            default: return 8'(sum);
        endcase
    endfunction

    function automatic logic [7:0] got_byte(input int k);
        if (k < sent_q.size()) return sent_q[k];
        return 8'hxx;
    endfunction

    task automatic pulse_update(input int x, input int y, output int uc);
        @(negedge clk);
        x_in = 11'(x);
        y_in = 11'(y);
        upd  = 1'b1;
        uc   = cyc;
        @(negedge clk);
        upd  = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fd_cyc_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_en(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (en_idx >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; upd = 1'b0; man_flag = 1'b0; x_in = '0; y_in = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({txd_en, txd_data, busy, frame_done, timeout_err, drop_cnt} !== 20'h0)
            begin bad++; $display("FAIL reset_outputs got=%h want=0", {txd_en, txd_data, busy, frame_done, timeout_err, drop_cnt}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({txd_en, busy, drop_cnt} !== 10'h0)
            begin bad++; $display("FAIL idle_after_reset got=%h want=0", {txd_en, busy, drop_cnt}); end
    endtask

    task automatic test_basic;
        int base, fdb, uc, last;
        bit ok;
        flag_dly = 100;
        base = sent_q.size(); fdb = fd_cyc_q.size();
        pulse_update(1920, 1080, uc);
        wait_fd(fdb + 1, 3000, ok);
        repeat (3) @(negedge clk);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_frame_done got=timeout want=pulse"); end
        total++;
        if (sent_q.size() - base != FLEN)
            begin bad++; $display("FAIL basic_byte_count got=%0d want=%0d", sent_q.size() - base, FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (got_byte(base + i) !== exp_byte(1920, 1080, i))
                begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, got_byte(base + i), exp_byte(1920, 1080, i)); end
        end
        if (sent_q.size() - base == FLEN && ok) begin
            total++;
            if (en_cyc_q[base] != uc + 2)
                begin bad++; $display("FAIL basic_first_latency got=%0d want=%0d", en_cyc_q[base] - uc, 2); end
            for (int i = 1; i < FLEN; i++) begin
                total++;
                if (en_cyc_q[base + i] - en_cyc_q[base + i - 1] != flag_dly + 2)
                    begin bad++; $display("FAIL basic_spacing%0d got=%0d want=%0d", i, en_cyc_q[base + i] - en_cyc_q[base + i - 1], flag_dly + 2); end
            end
            last = en_cyc_q[base + FLEN - 1];
            total++;
            if (fd_cyc_q[fdb] != last + flag_dly + 1)
                begin bad++; $display("FAIL basic_done_latency got=%0d want=%0d", fd_cyc_q[fdb] - last, flag_dly + 1); end
        end
        total++;
        if (fd_cyc_q.size() - fdb != 1 || busy !== 1'b0)
            begin bad++; $display("FAIL basic_done_busy got=%0d/%b want=1/0", fd_cyc_q.size() - fdb, busy); end
    endtask

    task automatic test_spurious;
        int enb, fdb;
        bit saw_busy;
        enb = en_idx; fdb = fd_cyc_q.size(); saw_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            man_flag = 1'b1;
            @(negedge clk);
            man_flag = 1'b0;
            repeat ($urandom_range(1, 6)) begin
                @(negedge clk);
                if (busy !== 1'b0) saw_busy = 1'b1;
            end
        end
        total++;
        if (en_idx != enb || fd_cyc_q.size() != fdb || saw_busy)
            begin bad++; $display("FAIL spurious_idle got=en%0d/fd%0d/busy%b want=0/0/0", en_idx - enb, fd_cyc_q.size() - fdb, saw_busy); end
    endtask

    task automatic test_back_to_back;
        int base, fdb, uc;
        bit ok;
        flag_dly = 100;
        base = sent_q.size(); fdb = fd_cyc_q.size();
        pulse_update(300, 400, uc);
        repeat (50) @(negedge clk);
        pulse_update(100, 50, uc);
        repeat (10) @(negedge clk);
        pulse_update(200, 50, uc);
        exp_drop = exp_drop + 1;
        wait_fd(fdb + 2, 4000, ok);
        repeat (3) @(negedge clk);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_two_frames got=timeout want=2"); end
        total++;
        if (drop_cnt !== 8'(exp_drop))
            begin bad++; $display("FAIL b2b_drop_cnt got=%0d want=%0d", drop_cnt, exp_drop); end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (got_byte(base + i) !== exp_byte(300, 400, i) || got_byte(base + FLEN + i) !== exp_byte(200, 50, i))
                begin bad++; $display("FAIL b2b_byte%0d got=%h/%h want=%h/%h", i, got_byte(base + i), got_byte(base + FLEN + i), exp_byte(300, 400, i), exp_byte(200, 50, i)); end
        end
        if (ok && sent_q.size() - base == 2 * FLEN) begin
            total++;
            if (en_cyc_q[base + FLEN] - fd_cyc_q[fdb] != 3)
                begin bad++; $display("FAIL b2b_restart_gap got=%0d want=3", en_cyc_q[base + FLEN] - fd_cyc_q[fdb]); end
        end
    endtask

    task automatic test_coincident;
        int base, fdb, uc, xa, ya, xb, yb;
        bit ok;
        flag_dly = 30;
        xa = $urandom_range(0, 2047); ya = $urandom_range(0, 2047);
        xb = $urandom_range(0, 2047); yb = $urandom_range(0, 2047);
        base = sent_q.size(); fdb = fd_cyc_q.size();
        withhold_at = en_idx + FLEN - 1;
        pulse_update(xa, ya, uc);
        wait_en(withhold_at + 1, 2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL coinc_last_byte got=timeout want=sent"); end
        repeat (20) @(negedge clk);
        man_flag = 1'b1; upd = 1'b1; x_in = 11'(xb); y_in = 11'(yb);
        @(negedge clk);
        man_flag = 1'b0; upd = 1'b0;
        withhold_at = -1;
        wait_fd(fdb + 2, 2000, ok);
        repeat (3) @(negedge clk);
        total++;
        if (!ok || fd_cyc_q.size() - fdb != 2)
            begin bad++; $display("FAIL coinc_frame_done got=%0d want=2", fd_cyc_q.size() - fdb); end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (got_byte(base + i) !== exp_byte(xa, ya, i) || got_byte(base + FLEN + i) !== exp_byte(xb, yb, i))
                begin bad++; $display("FAIL coinc_byte%0d got=%h/%h want=%h/%h", i, got_byte(base + i), got_byte(base + FLEN + i), exp_byte(xa, ya, i), exp_byte(xb, yb, i)); end
        end
        total++;
        if (drop_cnt !== 8'(exp_drop))
            begin bad++; $display("FAIL coinc_drop_cnt got=%0d want=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_timeout;
        int base, fdb, tob, uc, xa, ya;
        bit ok;
        flag_dly = 20;
        base = sent_q.size(); fdb = fd_cyc_q.size(); tob = to_cyc_q.size();
        withhold_at = en_idx + 2;
        pulse_update($urandom_range(0, 2047), $urandom_range(0, 2047), uc);
        ok = 1'b0;
        for (int i = 0; i < T + 1000; i++) begin
            @(negedge clk);
            if (to_cyc_q.size() > tob) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        withhold_at = -1;
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_pulse got=none want=pulse"); end
        if (ok && sent_q.size() - base >= 3) begin
            total++;
            if (to_cyc_q[tob] - en_cyc_q[base + 2] != T)
                begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", to_cyc_q[tob] - en_cyc_q[base + 2], T); end
        end
        total++;
        if (sent_q.size() - base != 3 || busy !== 1'b0 || fd_cyc_q.size() != fdb || to_cyc_q.size() - tob != 1)
            begin bad++; $display("FAIL timeout_abort got=bytes%0d/busy%b/to%0d want=3/0/1", sent_q.size() - base, busy, to_cyc_q.size() - tob); end
        xa = $urandom_range(0, 2047); ya = $urandom_range(0, 2047);
        base = sent_q.size();
        pulse_update(xa, ya, uc);
        wait_fd(fdb + 1, 2000, ok);
        repeat (3) @(negedge clk);
        total++;
        if (!ok || sent_q.size() - base != FLEN)
            begin bad++; $display("FAIL timeout_fresh_count got=%0d want=%0d", sent_q.size() - base, FLEN); end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (got_byte(base + i) !== exp_byte(xa, ya, i))
                begin bad++; $display("FAIL timeout_fresh_byte%0d got=%h want=%h", i, got_byte(base + i), exp_byte(xa, ya, i)); end
        end
    endtask

    task automatic test_drop_saturate;
        int base, fdb, uc, xl, yl;
        bit ok;
        flag_dly = 100;
        base = sent_q.size(); fdb = fd_cyc_q.size();
        pulse_update(5, 6, uc);
        xl = 0; yl = 0;
        for (int i = 0; i < 260; i++) begin
            xl = $urandom_range(0, 2047); yl = $urandom_range(0, 2047);
            pulse_update(xl, yl, uc);
        end
        exp_drop = (exp_drop + 259 > 255) ? 255 : exp_drop + 259;
        wait_fd(fdb + 2, 4000, ok);
        repeat (3) @(negedge clk);
        total++;
        if (!ok || drop_cnt !== 8'(exp_drop))
            begin bad++; $display("FAIL drop_saturate got=%0d want=%0d", drop_cnt, exp_drop); end
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (got_byte(base + FLEN + i) !== exp_byte(xl, yl, i))
                begin bad++; $display("FAIL drop_latest_byte%0d got=%h want=%h", i, got_byte(base + FLEN + i), exp_byte(xl, yl, i)); end
        end
    endtask

    task automatic test_reset_midframe;
        int base, enb, fdb, uc, xa, ya;
        bit ok;
        flag_dly = 100;
        enb = en_idx;
        pulse_update($urandom_range(0, 2047), $urandom_range(0, 2047), uc);
        wait_en(enb + 4, 2000, ok);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({txd_en, txd_data, busy, frame_done, timeout_err, drop_cnt} !== 20'h0)
            begin bad++; $display("FAIL midframe_async_reset got=%h want=0", {txd_en, txd_data, busy, frame_done, timeout_err, drop_cnt}); end
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        enb = en_idx;
        repeat (300) @(negedge clk);
        total++;
        if (en_idx != enb || busy !== 1'b0 || drop_cnt !== 8'(exp_drop))
            begin bad++; $display("FAIL midframe_no_resend got=en%0d/busy%b/drop%0d want=0/0/0", en_idx - enb, busy, drop_cnt); end
        xa = $urandom_range(0, 2047); ya = $urandom_range(0, 2047);
        base = sent_q.size(); fdb = fd_cyc_q.size();
        pulse_update(xa, ya, uc);
        wait_fd(fdb + 1, 2000, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < FLEN; i++) begin
            total++;
            if (got_byte(base + i) !== exp_byte(xa, ya, i))
                begin bad++; $display("FAIL midframe_fresh_byte%0d got=%h want=%h", i, got_byte(base + i), exp_byte(xa, ya, i)); end
        end
    endtask

    task automatic test_random;
        int base, fdb, uc, xa, ya;
        bit ok;
        for (int n = 0; n < 4; n++) begin
            flag_dly = $urandom_range(1, 40);
            xa = $urandom_range(0, 2047); ya = $urandom_range(0, 2047);
            base = sent_q.size(); fdb = fd_cyc_q.size();
            pulse_update(xa, ya, uc);
            // Inputs wander after the pulse; the frame must keep the captured values.
            x_in = 11'($urandom_range(0, 2047));
            y_in = 11'($urandom_range(0, 2047));
            wait_fd(fdb + 1, 1000, ok);
            repeat (3) @(negedge clk);
            total++;
            if (!ok || sent_q.size() - base != FLEN || busy !== 1'b0)
                begin bad++; $display("FAIL rand%0d_frame got=%0d/busy%b want=%0d/0", n, sent_q.size() - base, busy, FLEN); end
            for (int i = 0; i < FLEN; i++) begin
                total++;
                if (got_byte(base + i) !== exp_byte(xa, ya, i))
                    begin bad++; $display("FAIL rand%0d_byte%0d got=%h want=%h", n, i, got_byte(base + i), exp_byte(xa, ya, i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_spurious();
        test_back_to_back();
        test_coincident();
        test_timeout();
        test_drop_saturate();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
